// File: rtl/uart_rx_engine_if.sv
// UART receive handshake bundle: serial line in, byte/flags out.
// The engine uses the slave view, the consuming core the master view.
interface uart_rx_engine_if;
  logic       rxIn;
  logic       rdAck;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  modport master (
    output rxIn,
    output rdAck,
    input  rxData,
    input  rxValid,
    input  frameErr,
    input  overrun,
    input  busy
  );

  modport slave (
    input  rxIn,
    input  rdAck,
    output rxData,
    output rxValid,
    output frameErr,
    output overrun,
    output busy
  );
endinterface

// File: rtl/uart_rx_engine.sv
// 8N1 UART receive engine with mid-bit sampling.
// Received bytes are held for the core until acknowledged; error flags are sticky.
module uart_rx_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rstn,
  uart_rx_engine_if.slave   bus
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             ack;

  assign ack = valid_q & bus.rdAck;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (ack) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.rxIn) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (bus.rxIn) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {bus.rxIn, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (bus.rxIn) begin
            // A completing frame beats a same-edge ack: the new byte stays valid.
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !bus.rdAck) ovr_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (bus.rxIn) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rxData   = data_q;
  assign bus.rxValid  = valid_q;
  assign bus.frameErr = ferr_q;
  assign bus.overrun  = ovr_q;
  assign bus.busy     = (state_q != IDLE);

endmodule
